// File: rtl/db9_sega_pad_reader.sv
// DB9 joystick scanner for Atari sticks and Megadrive 3/6-button pads.
// Define SEGA_6BTN_EN for the 8-phase scan with 6-button detection; otherwise 4 phases.
module db9_sega_pad_reader #(
  parameter int SETTLE_CYCLES = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vertical_retrace_int_n,
  input  logic [5:0] db9_pins,
  output logic       db9_select,
  output logic [5:0] db9joy_out,
  output logic [5:0] db9ext_out,
  output logic [1:0] pad_type,
  output logic       scan_busy
);

`ifdef SEGA_6BTN_EN
  localparam int NUM_PHASES = 8;
`else
  localparam int NUM_PHASES = 4;
`endif
  localparam int PW = $clog2(NUM_PHASES);
  localparam logic [2:0] LAST_PHASE  = 3'(NUM_PHASES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PHASE, LATCH} state_t;

  state_t      state, state_next;
  logic [5:0]  pins_s1, pins_s2;
  logic        vr_s1, vr_s2, vr_prev;
  logic [2:0]  phase;
  logic [7:0]  settle;
  logic [5:0]  sample [NUM_PHASES];
  logic        retrace_fall, settle_done, sega, six;
  logic [3:0]  ext_hi;
  logic [1:0]  ext_lo;

  // Idle-high reset values so a released line never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pins_s1 <= 6'h3F;
      pins_s2 <= 6'h3F;
      vr_s1   <= 1'b1;
      vr_s2   <= 1'b1;
      vr_prev <= 1'b1;
    end else begin
      pins_s1 <= db9_pins;
      pins_s2 <= pins_s1;
      vr_s1   <= vertical_retrace_int_n;
      vr_s2   <= vr_s1;
      vr_prev <= vr_s2;
    end
  end

  assign retrace_fall = vr_prev & ~vr_s2;
  assign settle_done  = (settle == SETTLE_LAST);
  assign scan_busy    = (state != IDLE);
  assign db9_select   = (state == PHASE) ? ~phase[0] : 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (retrace_fall) state_next = PHASE;
      PHASE:   if (settle_done && phase == LAST_PHASE) state_next = LATCH;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Pins are captured at the end of each phase, after the pad has settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= 3'd0;
      settle <= 8'd0;
    end else if (state == PHASE) begin
      if (settle_done) begin
        sample[phase[PW-1:0]] <= pins_s2;
        settle <= 8'd0;
        if (phase != LAST_PHASE) phase <= phase + 3'd1;
      end else begin
        settle <= settle + 8'd1;
      end
    end else begin
      phase  <= 3'd0;
      settle <= 8'd0;
    end
  end

  assign sega   = (sample[1][1:0] == 2'b00);
  assign ext_lo = sega ? {sample[1][4], sample[1][5]} : 2'b11;
`ifdef SEGA_6BTN_EN
  assign six    = sega && (sample[5][3:0] == 4'b0000);
  assign ext_hi = six ? {sample[6][0], sample[6][1], sample[6][2], sample[6][3]} : 4'hF;
`else
  assign six    = 1'b0;
  assign ext_hi = 4'hF;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      db9joy_out <= 6'h3F;
      db9ext_out <= 6'h3F;
      pad_type   <= 2'd0;
    end else if (state == LATCH) begin
      db9joy_out <= sample[0];
      db9ext_out <= {ext_hi, ext_lo};
      pad_type   <= six ? 2'd2 : (sega ? 2'd1 : 2'd0);
    end
  end

endmodule

// File: tb/tb_db9_sega_pad_reader.sv
// Randomized bench for db9_sega_pad_reader driven by behavioural pad models.
// Honours SEGA_6BTN_EN to select the 8- or 4-phase expectations.
module tb_db9_sega_pad_reader;
  localparam int S = 6;
`ifdef SEGA_6BTN_EN
  localparam int NUM = 8;
  localparam bit SIX_EN = 1'b1;
`else
  localparam int NUM = 4;
  localparam bit SIX_EN = 1'b0;
`endif

  typedef struct packed {
    logic up, down, left, right, a, b, c, start, x, y, z, mode;
  } btn_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       vr;
  logic [5:0] pins;
  logic       db9_select;
  logic [5:0] db9joy_out, db9ext_out;
  logic [1:0] pad_type;
  logic       scan_busy;

  int   errors = 0;
  int   checks = 0;
  int   pad_kind = 0;
  btn_t btn = '0;
  int   cyc = 0;
  int   toggles = 0;
  int   start_cyc = 0;
  logic sel_q = 1'b1;
  logic busy_q = 1'b0;
  int   toggle_times[$];

  always #5 clk = ~clk;

  db9_sega_pad_reader #(.SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .rst(rst),
    .vertical_retrace_int_n(vr),
    .db9_pins(pins),
    .db9_select(db9_select),
    .db9joy_out(db9joy_out),
    .db9ext_out(db9ext_out),
    .pad_type(pad_type),
    .scan_busy(scan_busy)
  );

  // Pad answer as a function of how many select toggles it has seen this scan.
  function automatic logic [5:0] padWord(input int kind, input btn_t p, input int k);
    logic [5:0] hi, lo;
    hi = ~{p.c, p.b, p.up, p.down, p.left, p.right};
    lo = {~p.start, ~p.a, ~p.up, ~p.down, 2'b00};
    if (kind == 0) return hi;
    if (kind == 2 && k == 5) return {~p.start, ~p.a, 4'b0000};
    if (kind == 2 && k == 6) return ~{p.c, p.b, p.z, p.y, p.x, p.mode};
    return (k % 2 == 1) ? lo : hi;
  endfunction

  function automatic logic [13:0] expected(input int kind, input btn_t p);
    logic [5:0] joy, ext;
    logic [1:0] t;
    joy = ~{p.c, p.b, p.up, p.down, p.left, p.right};
    ext = 6'h3F;
    t   = 2'd0;
    if (kind >= 1) begin
      ext[1] = ~p.a;
      ext[0] = ~p.start;
      t = 2'd1;
    end
    if (kind == 2 && SIX_EN) begin
      ext[5:2] = ~{p.mode, p.x, p.y, p.z};
      t = 2'd2;
    end
    return {joy, ext, t};
  endfunction

  always_comb pins = padWord(pad_kind, btn, toggles);

  // Tracks select toggles per scan and their timing relative to scan start.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= scan_busy;
    sel_q  <= db9_select;
    if (scan_busy === 1'b1 && busy_q === 1'b0) begin
      start_cyc <= cyc;
      toggle_times.delete();
    end
    if (scan_busy !== 1'b1) toggles <= 0;
    else if (db9_select !== sel_q) begin
      toggles <= toggles + 1;
      toggle_times.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic runScan(input string name, input int kind, input btn_t p, input bit extra_edge);
    logic [13:0] prev, exp;
    int   w, n, good;
    bit   held, rescan;
    prev = {db9joy_out, db9ext_out, pad_type};
    exp  = expected(kind, p);
    @(negedge clk) vr = 1'b0;
    w = 0;
    while (scan_busy !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checkOutput({name, "_busy_start"}, scan_busy, 1);
    vr = 1'b1;
    if (scan_busy !== 1'b1) return;
    n = 0;
    held = 1'b1;
    while (scan_busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (extra_edge && n == 6) vr = 1'b0;
      if (extra_edge && n == 10) vr = 1'b1;
      if (scan_busy === 1'b1 && {db9joy_out, db9ext_out, pad_type} !== prev) held = 1'b0;
    end
    checkOutput({name, "_held"}, held, 1);
    checkOutput({name, "_latency"}, n, NUM * S + 1);
    checkOutput({name, "_joy"}, db9joy_out, exp[13:8]);
    checkOutput({name, "_ext"}, db9ext_out, exp[7:2]);
    checkOutput({name, "_type"}, pad_type, exp[1:0]);
    checkOutput({name, "_sel_count"}, toggle_times.size(), NUM);
    good = 0;
    foreach (toggle_times[i])
      if (toggle_times[i] - start_cyc == (i + 1) * S) good++;
    checkOutput({name, "_sel_timing"}, good, NUM);
    rescan = 1'b0;
    repeat (3 * S) begin
      @(negedge clk);
      if (scan_busy !== 1'b0) rescan = 1'b1;
    end
    checkOutput({name, "_no_rescan"}, rescan, 0);
  endtask

  task automatic applyStimulus(input string name, input int kind, input btn_t p, input bit extra_edge);
    @(negedge clk);
    pad_kind = kind;
    btn = p;
    repeat (4) @(negedge clk);
    runScan(name, kind, p, extra_edge);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    btn_t p;
    int   w;
    bit   late;
    rst = 1'b1;
    vr  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_select", db9_select, 1);
    checkOutput("rst_busy", scan_busy, 0);
    checkOutput("rst_joy", db9joy_out, 6'h3F);
    checkOutput("rst_ext", db9ext_out, 6'h3F);
    checkOutput("rst_type", pad_type, 0);

    p = '0; p.b = 1'b1; p.right = 1'b1;
    applyStimulus("plain", 0, p, 1'b0);

    // Reset landing in phase 3 must abort without touching the outputs.
    @(negedge clk) vr = 1'b0;
    p = '0; p.up = 1'b1; p.a = 1'b1;
    pad_kind = 1;
    btn = p;
    w = 0;
    while (toggles != 3 && w < 500) begin
      @(negedge clk);
      w++;
    end
    vr = 1'b1;
    checkOutput("midrst_reach_phase3", toggles, 3);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checkOutput("midrst_select", db9_select, 1);
    checkOutput("midrst_busy", scan_busy, 0);
    checkOutput("midrst_joy", db9joy_out, 6'h3F);
    late = 1'b0;
    repeat (NUM * S + 10) begin
      @(negedge clk);
      if (scan_busy !== 1'b0 || db9joy_out !== 6'h3F || pad_type !== 2'd0) late = 1'b1;
    end
    checkOutput("midrst_no_latch", late, 0);

    p = '0; p.up = 1'b1; p.b = 1'b1; p.a = 1'b1;
    applyStimulus("three_btn", 1, p, 1'b0);
    p = '0; p.z = 1'b1; p.mode = 1'b1;
    applyStimulus("six_btn", 2, p, 1'b1);
    applyStimulus("plain2", 0, '0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      p = btn_t'($urandom);
      if (p.up && p.down) p.down = 1'b0;
      if (p.left && p.right) p.right = 1'b0;
      applyStimulus($sformatf("rand%0d", i), $urandom_range(0, 2), p, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
